// File: rtl/mem_access_controller.sv
// mem_access_controller: single-outstanding load/store bus master for the MEMPREP stage.
// Optional bus timeout abort is enabled by defining MEMCTRL_TIMEOUT_EN.
module mem_access_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        invalid_MEMPREP,
  input  logic        mem_read_MEMPREP,
  input  logic        mem_write_MEMPREP,
  input  logic [1:0]  size_MEMPREP,
  input  logic        load_unsigned_MEMPREP,
  input  logic [31:0] addr_MEMPREP,
  input  logic [31:0] wdata_MEMPREP,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_fault,
  output logic        access_fault,
  output logic        timeout_fault
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;
  logic one_op, any_op, aligned, start, done, timeout_hit;
  logic [1:0] size_q, off_q;
  logic uns_q;
  logic [3:0] be_next;
  logic [31:0] wdata_next, lane, ext;

  assign one_op  = mem_read_MEMPREP ^ mem_write_MEMPREP;
  assign any_op  = mem_read_MEMPREP | mem_write_MEMPREP;
  assign aligned = size_MEMPREP == 2'b10 ? addr_MEMPREP[1:0] == 2'b00 :
                   size_MEMPREP == 2'b01 ? !addr_MEMPREP[0] : 1'b1;
  assign start   = state == IDLE && !invalid_MEMPREP && one_op && size_MEMPREP != 2'b11 && aligned;
  assign done    = state == BUSY && (mem_ack || timeout_hit);

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;

  always_comb begin
    state_next = state;
    if (start) state_next = BUSY;
    else if (done) state_next = IDLE;
  end

  always_comb begin
    stall      = start || (state == BUSY && !mem_ack && !timeout_hit);
    be_next    = size_MEMPREP == 2'b00 ? 4'b0001 << addr_MEMPREP[1:0] :
                 size_MEMPREP == 2'b01 ? (addr_MEMPREP[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_next = size_MEMPREP == 2'b00 ? {4{wdata_MEMPREP[7:0]}} :
                 size_MEMPREP == 2'b01 ? {2{wdata_MEMPREP[15:0]}} : wdata_MEMPREP;
    lane       = mem_rdata >> {off_q, 3'b000};
    ext        = size_q == 2'b00 ? {{24{!uns_q & lane[7]}}, lane[7:0]} :
                 size_q == 2'b01 ? {{16{!uns_q & lane[15]}}, lane[15:0]} : lane;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      load_data      <= '0;
      load_valid     <= 1'b0;
      misalign_fault <= 1'b0;
      access_fault   <= 1'b0;
      size_q         <= '0;
      off_q          <= '0;
      uns_q          <= 1'b0;
    end else begin
      misalign_fault <= state == IDLE && !invalid_MEMPREP && one_op && size_MEMPREP != 2'b11 && !aligned;
      access_fault   <= state == IDLE && !invalid_MEMPREP &&
                        ((mem_read_MEMPREP && mem_write_MEMPREP) || (any_op && size_MEMPREP == 2'b11));
      load_valid     <= 1'b0;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_write_MEMPREP;
        mem_addr  <= {addr_MEMPREP[31:2], 2'b00};
        mem_be    <= be_next;
        mem_wdata <= wdata_next;
        size_q    <= size_MEMPREP;
        off_q     <= addr_MEMPREP[1:0];
        uns_q     <= load_unsigned_MEMPREP;
      end else if (done) begin
        mem_req <= 1'b0;
        if (mem_ack && !mem_we) begin
          load_data  <= ext;
          load_valid <= 1'b1;
        end
      end
    end
  end

`ifdef MEMCTRL_TIMEOUT_EN
  logic [15:0] cnt;
  assign timeout_hit = state == BUSY && !mem_ack && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt           <= '0;
      timeout_fault <= 1'b0;
    end else begin
      timeout_fault <= timeout_hit;
      if (start) cnt <= '0;
      else if (state == BUSY && !mem_ack) cnt <= cnt + 16'd1;
    end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign timeout_fault  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: randomized transaction-level check of mem_access_controller.
module tb_mem_access_controller;
`ifdef MEMCTRL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic clk = 0, rst = 1;
  logic invalid_MEMPREP = 1, mem_read_MEMPREP = 0, mem_write_MEMPREP = 0, load_unsigned_MEMPREP = 0;
  logic [1:0] size_MEMPREP = 0;
  logic [31:0] addr_MEMPREP = 0, wdata_MEMPREP = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic mem_req, mem_we, stall, load_valid, misalign_fault, access_fault, timeout_fault;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0] mem_be;
  int checks = 0, failures = 0;
  logic [31:0] last_load = 0;

  mem_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .invalid_MEMPREP(invalid_MEMPREP),
    .mem_read_MEMPREP(mem_read_MEMPREP), .mem_write_MEMPREP(mem_write_MEMPREP),
    .size_MEMPREP(size_MEMPREP), .load_unsigned_MEMPREP(load_unsigned_MEMPREP),
    .addr_MEMPREP(addr_MEMPREP), .wdata_MEMPREP(wdata_MEMPREP),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misalign_fault(misalign_fault),
    .access_fault(access_fault), .timeout_fault(timeout_fault));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    invalid_MEMPREP = 1'($urandom);
    mem_read_MEMPREP = 1'($urandom);
    mem_write_MEMPREP = 1'($urandom);
    size_MEMPREP = 2'($urandom);
    load_unsigned_MEMPREP = 1'($urandom);
    addr_MEMPREP = $urandom;
    wdata_MEMPREP = $urandom;
    mem_rdata = $urandom;
  endtask

  task automatic do_op(input bit inv, input bit rd, input bit wr, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] w, input int waits, input bit [31:0] rdat);
    bit go, mis, acc;
    int off, v;
    bit [31:0] be_e, wd_e, ld_e, addr_e;
    off = int'(a % 4);
    mis = !inv && (rd != wr) && sz != 3 && ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0));
    acc = !inv && ((rd && wr) || ((rd || wr) && sz == 3));
    go = !inv && (rd != wr) && sz != 3 && !mis;
    addr_e = a - 32'(off);
    be_e = sz == 0 ? 32'(1 << off) : sz == 1 ? 32'(3 << off) : 32'hF;
    wd_e = sz == 0 ? (w % 256) * 32'h01010101 : sz == 1 ? (w % 65536) * 32'h00010001 : w;
    if (sz == 0) begin
      v = int'((rdat >> (8 * off)) % 256);
      if (!uns && v >= 128) v -= 256;
    end else if (sz == 1) begin
      v = int'((rdat >> (16 * (off / 2))) % 65536);
      if (!uns && v >= 32768) v -= 65536;
    end else v = int'(rdat);
    ld_e = 32'(v);
    invalid_MEMPREP = inv; mem_read_MEMPREP = rd; mem_write_MEMPREP = wr; size_MEMPREP = sz;
    load_unsigned_MEMPREP = uns; addr_MEMPREP = a; wdata_MEMPREP = w;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1 check("stall_idle", stall, go);
    tick;
    check("misalign", misalign_fault, mis);
    check("access", access_fault, acc);
    check("req_issue", mem_req, go);
    check("timeout_idle", timeout_fault, 0);
    if (!go) begin
      invalid_MEMPREP = 1; mem_ack = 1'($urandom);
      tick;
      check("misalign_pulse", misalign_fault, 0);
      check("access_pulse", access_fault, 0);
      check("no_req", mem_req, 0);
      check("no_lv", load_valid, 0);
      mem_ack = 0;
      return;
    end
    check("we", mem_we, wr);
    check("addr", mem_addr, addr_e);
    check("be", mem_be, be_e);
    check("wdata", mem_wdata, wd_e);
    for (int i = 0; i < waits; i++) begin
      scramble; mem_ack = 0;
      #1 check("stall_busy", stall, 1);
      tick;
      check("req_hold", mem_req, 1);
      check("addr_hold", mem_addr, addr_e);
      check("be_hold", mem_be, be_e);
      check("wdata_hold", mem_wdata, wd_e);
      check("we_hold", mem_we, wr);
      check("lv_wait", load_valid, 0);
    end
    mem_ack = 1; mem_rdata = rdat; invalid_MEMPREP = 1;
    #1 check("stall_ack", stall, 0);
    tick;
    mem_ack = 0;
    check("req_done", mem_req, 0);
    check("lv_done", load_valid, rd);
    if (rd) last_load = ld_e;
    check("load_data", load_data, last_load);
    tick;
    check("lv_pulse", load_valid, 0);
  endtask

  initial begin
    rst = 1;
    tick; tick;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    check("rst_ld", load_data, 0);
    check("rst_lv", load_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_faults", {misalign_fault, access_fault, timeout_fault}, 0);
    rst = 0;
    tick;
    do_op(0, 1, 0, 2, 0, 32'h100, 0, 3, 32'hDEADBEEF);
    check("word_load", load_data, 32'hDEADBEEF);
    do_op(0, 1, 0, 0, 0, 32'h203, 0, 1, 32'h80FFFFFF);
    check("sbyte_load", load_data, 32'hFFFFFF80);
    do_op(0, 1, 0, 0, 1, 32'h203, 0, 0, 32'h80FFFFFF);
    check("ubyte_load", load_data, 32'h00000080);
    do_op(0, 0, 1, 1, 0, 32'h102, 32'h1234ABCD, 2, 0);
    check("half_store_wdata", mem_wdata, 32'hABCDABCD);
    check("half_store_be", mem_be, 4'b1100);
    check("store_keeps_ld", load_data, 32'h00000080);
    do_op(0, 1, 0, 2, 0, 32'h101, 0, 0, 0);
    do_op(0, 1, 1, 2, 0, 32'h100, 0, 0, 0);
    do_op(0, 1, 0, 3, 0, 32'h100, 0, 0, 0);
    do_op(1, 1, 0, 2, 0, 32'h100, 0, 0, 0);
    // Reset in the second BUSY cycle while ack arrives must discard the ack.
    invalid_MEMPREP = 0; mem_read_MEMPREP = 1; mem_write_MEMPREP = 0; size_MEMPREP = 2; addr_MEMPREP = 32'h40;
    tick;
    invalid_MEMPREP = 1;
    tick;
    check("rst_busy_req", mem_req, 1);
    rst = 1; mem_ack = 1; mem_rdata = 32'h55AA55AA;
    tick;
    rst = 0; mem_ack = 0;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_lv", load_valid, 0);
    check("rst_mid_addr", mem_addr, 0);
    check("rst_mid_ld", load_data, 0);
    last_load = 0;
    tick;
    check("rst_mid_lv2", load_valid, 0);
    check("rst_mid_stall", stall, 0);
`ifdef MEMCTRL_TIMEOUT_EN
    invalid_MEMPREP = 0; mem_read_MEMPREP = 1; mem_write_MEMPREP = 0; size_MEMPREP = 2; addr_MEMPREP = 32'h80;
    #1 check("to_stall0", stall, 1);
    tick;
    invalid_MEMPREP = 1;
    for (int i = 0; i < TO; i++) begin
      #1 check("to_stall", stall, i < TO - 1);
      check("to_req", mem_req, 1);
      tick;
    end
    check("to_req_drop", mem_req, 0);
    check("to_fault", timeout_fault, 1);
    check("to_lv", load_valid, 0);
    tick;
    check("to_fault_pulse", timeout_fault, 0);
`endif
    for (int n = 0; n < 300; n++) begin
      int k;
      bit rd, wr;
      bit [1:0] sz;
      k = $urandom_range(0, 9);
      rd = k < 4 || k == 8;
      wr = (k >= 4 && k < 8) || k == 8;
      sz = 2'($urandom);
      if (!rd && !wr && sz == 3) sz = 2;
      do_op($urandom_range(0, 7) == 0, rd, wr, sz, 1'($urandom),
            $urandom, $urandom, $urandom_range(0, TO - 1 < 3 ? TO - 1 : 3), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_controller.md
MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles without mem_ack before abort (range 1..65535).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 invalid_MEMPREP  in  1  MEMPREP slot holds a bubble/flushed op.
REQ-005 mem_read_MEMPREP, mem_write_MEMPREP  in  1 each  load / store request.
REQ-006 size_MEMPREP  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 load_unsigned_MEMPREP  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 addr_MEMPREP, wdata_MEMPREP  in  32 each  effective address, store data.
REQ-009 mem_ack  in  1; mem_rdata  in  32  bus completion and read word.
REQ-010 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each; mem_be  out  4  bus request.
REQ-011 stall  out  1  freezes EX/MEMPREP and earlier pipeline registers.
REQ-012 load_data  out  32; load_valid  out  1  aligned, extended load result for MEMEX.
REQ-013 misalign_fault, access_fault, timeout_fault  out  1 each  one-cycle fault pulses.

Function
REQ-014 FSM states IDLE, BUSY; outputs except stall SHALL be registered.
REQ-015 start = IDLE & !invalid_MEMPREP & exactly one of read/write & size!=11 & aligned (half: addr[0]=0; word: addr[1:0]=0).
REQ-016 stall SHALL be combinational: (IDLE & start) | (BUSY & !mem_ack & !timeout_hit).
REQ-017 On start: next edge enter BUSY, mem_req=1, mem_we=write, mem_addr={addr[31:2],2'b00}, mem_be and lane-replicated mem_wdata latched.
REQ-018 mem_be: byte 1<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111; wdata byte replicated x4, half x2.
REQ-019 mem_req, mem_we, mem_addr, mem_be, mem_wdata SHALL remain stable throughout BUSY until the ack edge.
REQ-020 BUSY with mem_ack: next edge return IDLE, mem_req=0; for loads load_data = selected lane extended per size/load_unsigned, load_valid=1 for exactly one cycle.
REQ-021 Store completion SHALL leave load_valid=0 and load_data unchanged.
REQ-022 Minimum latency: request at edge N, ack in cycle N+1, load_valid in cycle N+2; stall cycles = 1 + ack wait cycles.
REQ-023 Misaligned valid access: misalign_fault pulse next cycle, no request, no stall.
REQ-024 Both read and write, or size=11, with valid slot: access_fault pulse next cycle, no request, no stall.
REQ-025 invalid_MEMPREP=1 in IDLE: no request, no fault, no stall.
REQ-026 mem_ack in IDLE SHALL be ignored; inputs sampled only in IDLE.

Reset
REQ-027 rst at any time, including mid-BUSY: next edge state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0, load_valid=0, all faults 0, timeout counter 0.
REQ-028 An ack arriving in the edge rst is asserted SHALL be discarded (no load_valid).

Configuration
REQ-029 MEMCTRL_TIMEOUT_EN defined: counter (16 bit) clears on BUSY entry, increments per BUSY cycle without ack; timeout_hit when count reaches TIMEOUT_CYCLES-1 without ack; next edge mem_req=0, IDLE, timeout_fault pulse, no load_valid; ack in same cycle wins over timeout.
REQ-030 MEMCTRL_TIMEOUT_EN undefined: no counter, timeout_hit=0, timeout_fault tied 0, BUSY waits indefinitely.

Verification
REQ-031 Word load addr 0x100, ack after 3 wait cycles, rdata 0xDEADBEEF -> mem_be 1111, stall 4 cycles, load_data 0xDEADBEEF, load_valid one cycle.
REQ-032 Signed byte load addr 0x203, rdata 0x80FFFFFF -> mem_be 1000, load_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 Half store addr 0x102, wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we=1, no load_valid.
REQ-034 Word load addr 0x101 -> misalign_fault one cycle, mem_req never 1, stall 0; read+write both set -> access_fault.
REQ-035 rst asserted second BUSY cycle with ack same cycle -> mem_req 0 next cycle, load_valid stays 0.
REQ-036 MEMCTRL_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, timeout_fault one cycle, stall released.
